// File: rtl/regfile_32x64.sv
// 32 x N architectural register file: one synchronous write port, two combinational read ports.
// Entry ZERO_REG is hardwired to zero. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_32x64 #(
  parameter int unsigned N        = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr_a,
  output logic [N-1:0] rd_data_a,
  input  logic [4:0]   rd_addr_b,
  output logic [N-1:0] rd_data_b
);

  localparam int unsigned DEPTH    = 32;
  localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);

  logic [N-1:0] regs [DEPTH];
  logic         wr_fire;

  assign wr_fire = wr_en && (wr_addr != ZERO_IDX);

  // Storage; the zero entry is never written so it stays at its reset value and is trimmed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != ZERO_IDX) begin
`ifdef REGFILE_BYPASS_EN
      if (!reset && wr_fire && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      else                                             rd_data_a = regs[rd_addr_a];
`else
      rd_data_a = regs[rd_addr_a];
`endif
    end
  end

  // Read port B
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != ZERO_IDX) begin
`ifdef REGFILE_BYPASS_EN
      if (!reset && wr_fire && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      else                                             rd_data_b = regs[rd_addr_b];
`else
      rd_data_b = regs[rd_addr_b];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed cases plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile_32x64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [63:0] rd_data_a;
  logic [4:0]  rd_addr_b = '0;
  logic [63:0] rd_data_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [63:0] model [32];

  regfile_32x64 #(.N(64), .ZERO_REG(31)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b)
  );

  always #5 clock = ~clock;

  // Reference: reset clears everything at once; otherwise a clock edge commits a non-zero-index write.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (wr_en && wr_addr != 5'd31) begin
      model[wr_addr] = wr_data;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31 || reset) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_a", rd_data_a, exp_rd(rd_addr_a));
      check("model_b", rd_data_b, exp_rd(rd_addr_b));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    step();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i); #1;
      check("reset_a", rd_data_a, 64'h0);
      check("reset_b", rd_data_b, 64'h0);
    end
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Write X3, read on both ports the next cycle
    do_write(5'd3, 64'hDEAD_BEEF_0123_4567);
    rd_addr_a = 5'd3; rd_addr_b = 5'd3; #1;
    check("x3_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    check("x3_b", rd_data_b, 64'hDEAD_BEEF_0123_4567);

    // wr_en=0 leaves X7 alone
    do_write(5'd7, 64'h55);
    step();
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 64'h1;
    step();
    rd_addr_a = 5'd7; #1;
    check("x7_hold", rd_data_a, 64'h55);

    // Writes to X31 are discarded
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr_a = 5'd31; rd_addr_b = 5'd3; #1;
    check("x31_zero", rd_data_a, 64'h0);
    check("x31_x3", rd_data_b, 64'hDEAD_BEEF_0123_4567);
    rd_addr_b = 5'd7; #1;
    check("x31_x7", rd_data_b, 64'h55);

    // Read-during-write on X9
    do_write(5'd9, 64'h2);
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA; rd_addr_a = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before", rd_data_a, 64'hA);
`else
    check("rdw_before", rd_data_a, 64'h2);
`endif
    step();
    wr_en = 1'b0; #1;
    check("rdw_after", rd_data_a, 64'hA);

    // Mid-cycle reset clears X5 without a clock edge
    do_write(5'd5, 64'h1234_5678_9ABC_DEF0);
    rd_addr_a = 5'd5; #1;
    check("x5_written", rd_data_a, 64'h1234_5678_9ABC_DEF0);
    #1 reset = 1'b1; #1;
    check("x5_async_clr", rd_data_a, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(i); #0.1;
      check("midrst_a", rd_data_a, 64'h0);
      check("midrst_b", rd_data_b, 64'h0);
    end
    step();
    reset = 1'b0;

    // Reset beats a coincident write to X4
    step();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h77; reset = 1'b1; rd_addr_a = 5'd4; #1;
    check("x4_rst_bypass", rd_data_a, 64'h0);
    step();
    reset = 1'b0; wr_en = 1'b0;
    step();
    check("x4_lost", rd_data_a, 64'h0);

    // Randomized traffic; read addresses frequently alias the write address
    for (int n = 0; n < 3000; n++) begin
      step();
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = {32'($urandom), 32'($urandom)};
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 149) == 0);
    end
    step();
    reset = 1'b0; wr_en = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
